// File: rtl/puf_codeword_assembler.sv
// PUF codeword assembler: gathers PUF response beats into a codeword, masks it
// with code-offset helper data, drives a BCH decoder wrapper and hands the
// decoded key out over a valid/ack handshake.
// Optional build macro: PUF_ASM_TIMEOUT_EN adds a decode watchdog that aborts
// a decode after C_TIMEOUT cycles in WAIT and pulses O_error.
module puf_codeword_assembler #(
   parameter int C_CODE_BITS = 15,
   parameter int C_DATA_BITS = 7,
   parameter int C_IN_BITS   = 1,
   parameter int C_TIMEOUT   = 1024
) (
   input  logic                   I_clk,
   input  logic                   I_rst,
   input  logic                   I_go,
   input  logic                   I_bit_valid,
   input  logic [C_IN_BITS-1:0]   I_bit,
   output logic                   O_bit_ready,
   input  logic [C_CODE_BITS-1:0] I_helper,
   output logic                   O_en,
   output logic                   O_start,
   output logic [C_CODE_BITS-1:0] O_data,
   input  logic                   I_dec_ready,
   input  logic [C_DATA_BITS-1:0] I_dec_data,
   output logic [C_DATA_BITS-1:0] O_key,
   output logic                   O_key_valid,
   input  logic                   I_key_ack,
   output logic                   O_error
);

   localparam int C_BEATS = C_CODE_BITS / C_IN_BITS;
   localparam int CNT_W   = $clog2(C_BEATS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_LAUNCH,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       beat_cnt;
   logic [C_CODE_BITS-1:0] shift_q;
   logic [C_CODE_BITS-1:0] shift_next;
   logic                   beat_take;
   logic                   beat_last;
   logic                   en_d;
   logic                   start_d;
   logic                   ready_d;
   logic                   valid_d;

   // New beat enters at the LSBs so the first beat ends up in the MSBs
   assign shift_next = (shift_q << C_IN_BITS) | C_CODE_BITS'(I_bit);
   assign beat_take  = (state_q == S_COLLECT) && I_bit_valid;
   assign beat_last  = beat_take && (beat_cnt == CNT_W'(C_BEATS - 1));

`ifdef PUF_ASM_TIMEOUT_EN
   localparam int WDOG_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

   logic [WDOG_W-1:0] wait_cnt;
   logic              timeout_hit;

   // Watchdog counts cycles spent in WAIT and restarts from zero on every entry
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         wait_cnt <= '0;
      end else if (state_q == S_WAIT) begin
         wait_cnt <= wait_cnt + WDOG_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Decoder completion in the final watchdog cycle takes priority over the abort
   assign timeout_hit = (state_q == S_WAIT) && !I_dec_ready &&
                        (wait_cnt == WDOG_W'(C_TIMEOUT - 1));

   // Error flag is a registered single-cycle pulse following the abort
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         O_error <= 1'b0;
      end else begin
         O_error <= timeout_hit;
      end
   end
`else
   assign O_error = 1'b0;
`endif

   // State register
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; requests arriving in the wrong state are simply ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (I_go) state_d = S_COLLECT;
         S_COLLECT: if (beat_last) state_d = S_LAUNCH;
         S_LAUNCH:  state_d = S_WAIT;
         S_WAIT: begin
            if (I_dec_ready) begin
               state_d = S_OUTPUT;
            end
`ifdef PUF_ASM_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = S_IDLE;
            end
`endif
         end
         S_OUTPUT:  if (I_key_ack) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up with it
   always_comb begin
      en_d    = (state_d == S_LAUNCH) || (state_d == S_WAIT);
      start_d = (state_d == S_WAIT);
      ready_d = (state_d == S_COLLECT);
      valid_d = (state_d == S_OUTPUT);
   end

   // Control outputs are registered to keep the decoder interface glitch-free
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         O_en        <= 1'b0;
         O_start     <= 1'b0;
         O_bit_ready <= 1'b0;
         O_key_valid <= 1'b0;
      end else begin
         O_en        <= en_d;
         O_start     <= start_d;
         O_bit_ready <= ready_d;
         O_key_valid <= valid_d;
      end
   end

   // Datapath: beat collection, masked codeword launch and key capture
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         beat_cnt <= '0;
         shift_q  <= '0;
         O_data   <= '0;
         O_key    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (I_go) begin
                  beat_cnt <= '0;
                  shift_q  <= '0;
               end
            end
            S_COLLECT: begin
               if (beat_take) begin
                  shift_q  <= shift_next;
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
               if (beat_last) begin
                  O_data <= shift_next ^ I_helper;
               end
            end
            S_WAIT: begin
               if (I_dec_ready) begin
                  O_key <= I_dec_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_codeword_assembler.sv
// Directed self-checking bench for puf_codeword_assembler (15/7/1 configuration).
module tb_puf_codeword_assembler;

   localparam int C_CODE_BITS = 15;
   localparam int C_DATA_BITS = 7;
   localparam int C_IN_BITS   = 1;
   localparam int C_TIMEOUT   = 64;

   logic                   I_clk;
   logic                   I_rst;
   logic                   I_go;
   logic                   I_bit_valid;
   logic [C_IN_BITS-1:0]   I_bit;
   logic                   O_bit_ready;
   logic [C_CODE_BITS-1:0] I_helper;
   logic                   O_en;
   logic                   O_start;
   logic [C_CODE_BITS-1:0] O_data;
   logic                   I_dec_ready;
   logic [C_DATA_BITS-1:0] I_dec_data;
   logic [C_DATA_BITS-1:0] O_key;
   logic                   O_key_valid;
   logic                   I_key_ack;
   logic                   O_error;

   int n_cmp = 0;
   int n_err = 0;

   puf_codeword_assembler #(
      .C_CODE_BITS(C_CODE_BITS),
      .C_DATA_BITS(C_DATA_BITS),
      .C_IN_BITS  (C_IN_BITS),
      .C_TIMEOUT  (C_TIMEOUT)
   ) dut (
      .I_clk      (I_clk),
      .I_rst      (I_rst),
      .I_go       (I_go),
      .I_bit_valid(I_bit_valid),
      .I_bit      (I_bit),
      .O_bit_ready(O_bit_ready),
      .I_helper   (I_helper),
      .O_en       (O_en),
      .O_start    (O_start),
      .O_data     (O_data),
      .I_dec_ready(I_dec_ready),
      .I_dec_data (I_dec_data),
      .O_key      (O_key),
      .O_key_valid(O_key_valid),
      .I_key_ack  (I_key_ack),
      .O_error    (O_error)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      I_clk = 1'b0;
      forever #5 I_clk = ~I_clk;
   end

   // Advance one rising edge and settle past it before looking at outputs
   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   // One comparison point: counts it and reports any disagreement
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Feed beats of a codeword MSB-first, optionally with an idle cycle before each
   task automatic applyStimulus(input logic [14:0] word, input bit gaps, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         if (gaps) begin
            I_bit_valid = 1'b0;
            I_bit       = 1'b1;
            tick();
         end
         I_bit       = word[14-i];
         I_bit_valid = 1'b1;
         tick();
      end
      I_bit_valid = 1'b0;
      I_bit       = 1'b0;
   endtask

   // Directed sequence
   initial begin
      int bad;
      int err_pulses;
      int first_err;

      I_rst = 1'b1; I_go = 1'b0; I_bit_valid = 1'b0; I_bit = 1'b0;
      I_helper = '0; I_dec_ready = 1'b0; I_dec_data = '0; I_key_ack = 1'b0;

      // Reset state, with other inputs active to show reset dominates
      I_go = 1'b1;
      tick();
      tick();
      checkOutput("rst_en",        O_en,        0);
      checkOutput("rst_start",     O_start,     0);
      checkOutput("rst_bit_ready", O_bit_ready, 0);
      checkOutput("rst_key_valid", O_key_valid, 0);
      checkOutput("rst_error",     O_error,     0);
      checkOutput("rst_data",      O_data,      0);
      checkOutput("rst_key",       O_key,       0);
      I_rst = 1'b0;
      I_go  = 1'b0;

      // Collect 0x4D2B, mask with 0x0F0F -> 0x4224
      I_helper = 15'h0F0F;
      I_go = 1'b1;
      tick();
      I_go = 1'b0;
      checkOutput("collect_ready", O_bit_ready, 1);
      applyStimulus(15'h4D2B, 1'b0, 15);
      checkOutput("launch_data",  O_data,      15'h4224);
      checkOutput("launch_en",    O_en,        1);
      checkOutput("launch_start", O_start,     0);
      checkOutput("launch_ready", O_bit_ready, 0);
      tick();
      checkOutput("wait_en",    O_en,    1);
      checkOutput("wait_start", O_start, 1);
      bad = 0;
      for (int i = 0; i < 39; i++) begin
         tick();
         if (O_start !== 1'b1 || O_en !== 1'b1 || O_data !== 15'h4224) bad++;
      end
      checkOutput("wait_hold", bad, 0);
      I_dec_ready = 1'b1;
      I_dec_data  = 7'h55;
      tick();
      I_dec_ready = 1'b0;
      I_dec_data  = 7'h00;
      checkOutput("out_valid", O_key_valid, 1);
      checkOutput("out_key",   O_key,       7'h55);
      checkOutput("out_en",    O_en,        0);
      checkOutput("out_start", O_start,     0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (O_key_valid !== 1'b1) bad++;
      end
      checkOutput("out_hold_valid", bad, 0);
      I_key_ack = 1'b1;
      tick();
      I_key_ack = 1'b0;
      checkOutput("ack_valid", O_key_valid, 0);
      checkOutput("ack_key",   O_key,       7'h55);
      checkOutput("ack_idle",  O_bit_ready, 0);

      // Same codeword with gaps; stray go/bit/ack during WAIT are ignored
      I_go = 1'b1;
      tick();
      I_go = 1'b0;
      applyStimulus(15'h4D2B, 1'b1, 15);
      checkOutput("gap_data", O_data, 15'h4224);
      tick();
      I_go = 1'b1; I_bit_valid = 1'b1; I_bit = 1'b1; I_key_ack = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      I_go = 1'b0; I_bit_valid = 1'b0; I_bit = 1'b0;
      checkOutput("stray_start", O_start,     1);
      checkOutput("stray_ready", O_bit_ready, 0);
      checkOutput("stray_valid", O_key_valid, 0);
      checkOutput("stray_data",  O_data,      15'h4224);
      // Ack already high when the key arrives: valid lasts one cycle
      I_dec_ready = 1'b1;
      I_dec_data  = 7'h2A;
      tick();
      I_dec_ready = 1'b0;
      checkOutput("ackhi_valid", O_key_valid, 1);
      checkOutput("ackhi_key",   O_key,       7'h2A);
      tick();
      I_key_ack = 1'b0;
      checkOutput("ackhi_drop", O_key_valid, 0);
      checkOutput("ackhi_keep", O_key,       7'h2A);

      // Reset after 8 beats clears everything
      I_helper = 15'h7FFF;
      I_go = 1'b1;
      tick();
      I_go = 1'b0;
      applyStimulus(15'h1234, 1'b0, 8);
      I_rst = 1'b1;
      tick();
      I_rst = 1'b0;
      checkOutput("midrst_ready", O_bit_ready, 0);
      checkOutput("midrst_key",   O_key,       0);
      checkOutput("midrst_data",  O_data,      0);
      checkOutput("midrst_en",    O_en,        0);
      // Go accepted in the first post-reset cycle; 0x1234 ^ 0x7FFF -> 0x6DCB
      I_go = 1'b1;
      tick();
      I_go = 1'b0;
      checkOutput("postrst_ready", O_bit_ready, 1);
      applyStimulus(15'h1234, 1'b0, 15);
      checkOutput("postrst_data", O_data, 15'h6DCB);
      tick();

      // Decoder never answers
      err_pulses = 0;
      first_err  = -1;
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (O_error === 1'b1) begin
            err_pulses++;
            if (first_err < 0) first_err = i;
         end
      end
`ifdef PUF_ASM_TIMEOUT_EN
      checkOutput("tmo_pulses", err_pulses, 1);
      checkOutput("tmo_when",   first_err,  C_TIMEOUT);
      checkOutput("tmo_en",     O_en,       0);
      checkOutput("tmo_key",    O_key,      0);
`else
      checkOutput("notmo_pulses", err_pulses, 0);
      checkOutput("notmo_start",  O_start,    1);
      checkOutput("notmo_en",     O_en,       1);
`endif

      // Reset in the middle of a decode
      I_rst = 1'b1;
      tick();
      I_rst = 1'b0;
      checkOutput("decrst_en",    O_en,    0);
      checkOutput("decrst_start", O_start, 0);
      checkOutput("decrst_data",  O_data,  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
